// File: rtl/spi_master_core.sv
// SPI master shift engine: one chip-select frame of 8..64 bits, MSB first, CPHA=0.
// clk runs at twice SCLK, so each SCLK half-period is exactly one clk.
module spi_master_core #(
   parameter bit CPOL     = 1'b0,
   parameter int CS_SETUP = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] data_in,
   input  logic [2:0]  byte_num,
   output logic        busy,
   output logic        busy_reg,
   output logic        finished,
   output logic [63:0] rx_data,
   output logic        sclk,
   output logic        cs_n,
   output logic        mosi,
   input  logic        miso
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] SHIFT = 3'd2;
   localparam logic [2:0] HOLD  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]  state;
   logic [7:0]  setup_cnt;
   logic [63:0] tx_sr;
   logic [63:0] rx_sr;
   logic [6:0]  bit_cnt;
   logic [6:0]  n_last;
   logic [6:0]  n_bits;
   logic [63:0] tx_aligned;
   logic        load;
   logic        trail;
   logic        last_bit;

   // Left-align the frame so the first bit to send always sits at bit 63.
   always_comb begin
      n_bits     = (byte_num == 3'd0) ? 7'd64 : {1'b0, byte_num, 3'b000};
      tx_aligned = data_in << (7'd64 - n_bits);
      load       = (state == IDLE) && start;
      trail      = (state == SHIFT) && (sclk != CPOL);
      last_bit   = (bit_cnt == n_last);
   end

   always_ff @(posedge clk) begin
      if (load) begin
         tx_sr   <= tx_aligned << 1;
         rx_sr   <= '0;
         bit_cnt <= '0;
         n_last  <= n_bits - 7'd1;
      end else if (trail) begin
         rx_sr <= {rx_sr[62:0], miso};
         if (!last_bit) begin
            tx_sr   <= tx_sr << 1;
            bit_cnt <= bit_cnt + 7'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         setup_cnt <= '0;
         busy      <= 1'b0;
         busy_reg  <= 1'b0;
         finished  <= 1'b0;
         rx_data   <= '0;
         sclk      <= CPOL;
         cs_n      <= 1'b1;
         mosi      <= 1'b0;
      end else begin
         busy_reg <= busy;
         case (state)
            IDLE: begin
               if (start) begin
                  cs_n      <= 1'b0;
                  busy      <= 1'b1;
                  mosi      <= tx_aligned[63];
                  setup_cnt <= '0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (setup_cnt == 8'(CS_SETUP - 1)) begin
                  sclk  <= ~CPOL;
                  state <= SHIFT;
               end else begin
                  setup_cnt <= setup_cnt + 8'd1;
               end
            end
            SHIFT: begin
               if (sclk == CPOL) begin
                  sclk <= ~CPOL;
               end else begin
                  // Trailing edge: MISO is captured in the data block; advance MOSI.
                  sclk <= CPOL;
                  if (last_bit) state <= HOLD;
                  else          mosi  <= tx_sr[63];
               end
            end
            HOLD: begin
               cs_n     <= 1'b1;
               busy     <= 1'b0;
               finished <= 1'b1;
               rx_data  <= rx_sr;
               state    <= DONE;
            end
            DONE: begin
               finished <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: CPOL=0 and CPOL=1 instances driven in lockstep,
// frames checked against a bit-level reference of the SPI frame.
module tb_spi_master_core;

   localparam int S = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] data_in = '0;
   logic [2:0]  byte_num = '0;
   logic        miso = 1'b0;

   logic        busy0, busy_reg0, fin0, sclk0, cs_n0, mosi0;
   logic        busy1, busy_reg1, fin1, sclk1, cs_n1, mosi1;
   logic [63:0] rx0, rx1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spi_master_core #(.CPOL(1'b0), .CS_SETUP(S)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .byte_num(byte_num),
      .busy(busy0), .busy_reg(busy_reg0), .finished(fin0), .rx_data(rx0),
      .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso));

   spi_master_core #(.CPOL(1'b1), .CS_SETUP(S)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .byte_num(byte_num),
      .busy(busy1), .busy_reg(busy_reg1), .finished(fin1), .rx_data(rx1),
      .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso));

   typedef struct {
      logic [63:0] data;
      logic [2:0]  bnum;
      bit          loopback;
      logic [63:0] rxw;
      logic [63:0] exp_mosi;
      logic [63:0] exp_rx;
      int          exp_fin;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: an N-bit frame sends data[N-1:0] MSB first, receives N MISO bits,
   // and finishes S + 2N clks after start is accepted.
   function automatic vec_t model(input logic [63:0] d, input logic [2:0] b,
                                  input bit lb, input logic [63:0] rw);
      vec_t v;
      int n;
      logic [63:0] mask;
      n    = (b == 3'd0) ? 64 : 8 * int'(b);
      mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
      v.data = d; v.bnum = b; v.loopback = lb; v.rxw = rw;
      v.exp_mosi = d & mask;
      v.exp_rx   = lb ? (d & mask) : (rw & mask);
      v.exp_fin  = S + 2 * n;
      return v;
   endfunction

   task automatic run_frame(input vec_t v, input bit noise);
      int n, lead, first_lead, fin_cnt, fin_at, cpol_err, early, breg_err;
      logic prev_s, prev_busy;
      logic [63:0] cap, rx_at;
      n = (v.bnum == 3'd0) ? 64 : 8 * int'(v.bnum);
      lead = 0; first_lead = -1; fin_cnt = 0; fin_at = -1;
      cpol_err = 0; early = 0; breg_err = 0; cap = '0; rx_at = '0;
      prev_s = sclk0;
      data_in = v.data; byte_num = v.bnum; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_ack", {62'd0, cs_n0, busy0}, 64'd1);
      prev_busy = busy0;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk); #1;
         if (sclk0 && !prev_s) begin
            cap = {cap[62:0], mosi0};
            if (first_lead < 0) first_lead = c;
            if (!v.loopback) miso = v.rxw[n - 1 - lead];
            lead++;
         end
         if (v.loopback) miso = mosi0;
         prev_s = sclk0;
         if (sclk1 !== ~sclk0 || mosi1 !== mosi0 || fin1 !== fin0 || cs_n1 !== cs_n0 ||
             busy1 !== busy0 || rx1 !== rx0) cpol_err++;
         if (busy_reg0 !== prev_busy) breg_err++;
         prev_busy = busy0;
         if (cs_n0 && fin_cnt == 0 && !fin0) early++;
         if (fin0) begin
            fin_cnt++;
            fin_at = c;
            rx_at  = rx0;
         end
         if (noise) begin
            if (c == 10) start = 1'b1;
            if (c == 11) start = 1'b0;
            if (c == 12) data_in = ~v.data;
            if (fin0) start = 1'b1;
         end
         if (fin_cnt > 0 && c == fin_at + 1) break;
      end
      start = 1'b0;
      chk("timeout", 64'(fin_cnt > 0), 64'd1);
      chk("mosi_bits", cap, v.exp_mosi);
      chk("lead_edges", 64'(lead), 64'(n));
      chk("first_lead", 64'(first_lead), 64'(S));
      chk("fin_time", 64'(fin_at), 64'(v.exp_fin));
      chk("fin_count", 64'(fin_cnt), 64'd1);
      chk("rx_data", rx_at, v.exp_rx);
      chk("cpol1_match", 64'(cpol_err), 64'd0);
      chk("cs_early", 64'(early), 64'd0);
      chk("busy_reg", 64'(breg_err), 64'd0);
      chk("end_state", {61'd0, fin0, cs_n0, busy0}, 64'd2);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{64'h05A2, 3'd2, 1'b0, {64{1'b1}}, 64'h05A2, 64'hFFFF, 33};
      vecs[1] = '{64'h0123456789ABCDEF, 3'd0, 1'b1, 64'd0,
                  64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 129};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FF81, 3'd1, 1'b0, 64'h5A, 64'h81, 64'h5A, 17};
      for (int i = 3; i < 10; i++)
         vecs[i] = model({$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         {$urandom, $urandom});

      repeat (3) @(posedge clk);
      #1;
      chk("reset_cpol0", {58'd0, busy0, busy_reg0, fin0, sclk0, cs_n0, mosi0}, 64'b000010);
      chk("reset_cpol1", {58'd0, busy1, busy_reg1, fin1, sclk1, cs_n1, mosi1}, 64'b000110);
      chk("reset_rx", rx0, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         run_frame(vecs[i], 1'b0);
         repeat (2) @(posedge clk);
         #1;
      end

      // Restart pulse and data change mid-frame, plus a start while DONE.
      run_frame(vecs[0], 1'b1);
      begin
         int hi;
         hi = 0;
         for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (cs_n0 && !busy0) hi++;
         end
         chk("no_requeue", 64'(hi), 64'd4);
      end

      // Back-to-back: second start raised in the clk after finished.
      run_frame(vecs[0], 1'b0);
      run_frame(model(64'h8200, 3'd2, 1'b0, {$urandom, $urandom}), 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // Asynchronous reset during bit 5 of a frame.
      begin
         int lead, fins;
         logic prev_s;
         lead = 0; fins = 0; prev_s = sclk0;
         data_in = 64'hA5C3; byte_num = 3'd2; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         for (int c = 0; c < 40 && lead < 6; c++) begin
            @(posedge clk); #1;
            if (sclk0 && !prev_s) lead++;
            prev_s = sclk0;
         end
         #2 rst_n = 1'b0;
         #1;
         chk("rst_mid_cpol0", {59'd0, busy0, fin0, sclk0, cs_n0, mosi0}, 64'b00010);
         chk("rst_mid_cpol1", {59'd0, busy1, fin1, sclk1, cs_n1, mosi1}, 64'b00110);
         for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (fin0 || fin1) fins++;
         end
         rst_n = 1'b1;
         for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (fin0 || fin1 || !cs_n0) fins++;
         end
         chk("rst_no_finish", 64'(fins), 64'd0);
      end
      run_frame(vecs[0], 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
